// File: rtl/musa_pc_pkg.sv
// Shared definitions for the PC / return-stack unit:
// next-PC source encodings and the default sequential step.
package musa_pc_pkg;

    typedef enum logic [1:0] {
        PC_SRC_STACK    = 2'b00,
        PC_SRC_REGISTER = 2'b01,
        PC_SRC_SEQUENCE = 2'b10,
        PC_SRC_RELATIVE = 2'b11
    } pc_src_e;

    localparam int DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// Return-address LIFO with a combined pop+push that replaces the top in place.
// Entries at or above the stack pointer are never presented on o_top.
module return_stack
    import musa_pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int SPW = $clog2(DEPTH + 1),
    localparam int AW  = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top,
    output logic [SPW-1:0]   o_sp,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;

    logic          w_empty;
    logic          w_full;
    logic          w_replace;
    logic          w_do_push;
    logic          w_do_pop;
    logic [AW-1:0] w_top_idx;
    logic [AW-1:0] w_wr_idx;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SPW'(DEPTH));
    assign w_top_idx = AW'(r_sp - SPW'(1));
    assign w_wr_idx  = AW'(r_sp);

    // A pop on an empty stack is ignored, so the push still goes ahead.
    assign w_replace = i_push && i_pop && !w_empty;
    assign w_do_pop  = i_pop && !i_push && !w_empty;
    assign w_do_push = i_push && !w_replace && !w_full;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SPW'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (w_replace) begin
                r_mem[w_top_idx] <= i_push_data;
            end else if (w_do_push) begin
                r_mem[w_wr_idx] <= i_push_data;
            end
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
    assign o_sp    = r_sp;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC selection and a call/return stack.
// Underflow and overflow raise a sticky error that only reset clears.
module pc_stack_unit
    import musa_pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 8,
    parameter int               PC_STEP  = DEFAULT_PC_STEP,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    localparam int              SPW      = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       pc_src,
    input  logic             push,
    input  logic [WIDTH-1:0] ready_data1,
    input  logic [WIDTH-1:0] relative_pc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_sequency,
    output logic [SPW-1:0]   sp,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_error
);

    logic [WIDTH-1:0] r_pc;
    logic             r_err;

    pc_src_e          w_src;
    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_top;
    logic [SPW-1:0]   w_sp;
    logic             w_pop;
    logic             w_push;
    logic             w_empty;
    logic             w_full;
    logic             w_underflow;
    logic             w_overflow;

    assign w_src  = pc_src_e'(pc_src);
    assign w_seq  = r_pc + WIDTH'(PC_STEP);
    assign w_pop  = !stall && (w_src == PC_SRC_STACK);
    assign w_push = !stall && push;

    assign w_underflow = w_pop && w_empty;
    assign w_overflow  = w_push && w_full && !w_pop;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_seq),
        .o_top       (w_top),
        .o_sp        (w_sp),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    always_comb begin
        w_next_pc = w_seq;
        unique case (w_src)
            PC_SRC_STACK:    w_next_pc = w_empty ? w_seq : w_top;
            PC_SRC_REGISTER: w_next_pc = ready_data1;
            PC_SRC_SEQUENCE: w_next_pc = w_seq;
            PC_SRC_RELATIVE: w_next_pc = r_pc + relative_pc;
            default:         w_next_pc = w_seq;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_err <= 1'b0;
        end else if (!stall) begin
            r_pc <= w_next_pc;
            if (w_underflow || w_overflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_sequency = w_seq;
    assign sp          = w_sp;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_error = r_err;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: vector table, directed call/return sequences,
// and random traffic against a queue-based model.
module tb_pc_stack_unit;

    localparam logic [1:0] STK = 2'b00;
    localparam logic [1:0] REG = 2'b01;
    localparam logic [1:0] SEQ = 2'b10;
    localparam logic [1:0] REL = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_src;
    logic        push;
    logic [31:0] ready_data1;
    logic [31:0] relative_pc;
    logic [31:0] pc;
    logic [31:0] pc_sequency;
    logic [3:0]  sp;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_error;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    bit          m_err;

    always #5 clock = ~clock;

    pc_stack_unit dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .pc_src      (pc_src),
        .push        (push),
        .ready_data1 (ready_data1),
        .relative_pc (relative_pc),
        .pc          (pc),
        .pc_sequency (pc_sequency),
        .sp          (sp),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_error (stack_error)
    );

    typedef struct {
        bit          rst;
        bit          stl;
        logic [1:0]  src;
        bit          psh;
        logic [31:0] rd;
        logic [31:0] rel;
        logic [31:0] e_pc;
        int          e_sp;
        bit          e_err;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference behaviour: queue back is the top of stack.
    task automatic model_tick(input bit rst, input bit stl,
                              input logic [1:0] src, input bit psh,
                              input logic [31:0] rd, input logic [31:0] rel);
        logic [31:0] seq;
        logic [31:0] npc;
        if (rst) begin
            m_pc = 32'h0;
            m_stk.delete();
            m_err = 0;
        end else if (!stl) begin
            seq = m_pc + 32'd4;
            npc = seq;
            case (src)
                STK: begin
                    if (m_stk.size() > 0) npc = m_stk.pop_back();
                    else m_err = 1;
                end
                REG:     npc = rd;
                SEQ:     npc = seq;
                default: npc = m_pc + rel;
            endcase
            if (psh) begin
                if (m_stk.size() < 8) m_stk.push_back(seq);
                else m_err = 1;
            end
            m_pc = npc;
        end
    endtask

    task automatic apply(input bit rst, input bit stl, input logic [1:0] src,
                         input bit psh, input logic [31:0] rd,
                         input logic [31:0] rel);
        reset       = rst;
        stall       = stl;
        pc_src      = src;
        push        = psh;
        ready_data1 = rd;
        relative_pc = rel;
        @(posedge clock);
        model_tick(rst, stl, src, psh, rd, rel);
        #1;
        chk("model_pc", pc, m_pc);
        chk("model_sp", 32'(sp), 32'(m_stk.size()));
        chk("model_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
        chk("model_full", 32'(stack_full), 32'(m_stk.size() == 8));
        chk("model_err", 32'(stack_error), 32'(m_err));
        chk("model_pcseq", pc_sequency, m_pc + 32'd4);
    endtask

    task automatic chk_state(input string nm, input logic [31:0] e_pc,
                             input int e_sp, input bit e_err);
        chk({nm, "_pc"}, pc, e_pc);
        chk({nm, "_sp"}, 32'(sp), 32'(e_sp));
        chk({nm, "_err"}, 32'(stack_error), 32'(e_err));
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        pc_src      = SEQ;
        push        = 1'b0;
        ready_data1 = '0;
        relative_pc = '0;

        tbl[0]  = '{1, 0, SEQ, 0, 32'h0, 32'h0, 32'h0, 0, 0};
        tbl[1]  = '{0, 0, SEQ, 0, 32'h0, 32'h0, 32'h4, 0, 0};
        tbl[2]  = '{0, 0, SEQ, 0, 32'h0, 32'h0, 32'h8, 0, 0};
        tbl[3]  = '{0, 0, SEQ, 0, 32'h0, 32'h0, 32'hC, 0, 0};
        tbl[4]  = '{0, 0, REG, 0, 32'h100, 32'h0, 32'h100, 0, 0};
        tbl[5]  = '{0, 0, REG, 1, 32'h400, 32'h0, 32'h400, 1, 0};
        tbl[6]  = '{0, 0, STK, 0, 32'h0, 32'h0, 32'h104, 0, 0};
        tbl[7]  = '{0, 0, REG, 0, 32'h10, 32'h0, 32'h10, 0, 0};
        tbl[8]  = '{0, 0, REL, 0, 32'h0, 32'hFFFFFFF8, 32'h8, 0, 0};
        tbl[9]  = '{0, 0, REG, 0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 0, 0};
        tbl[10] = '{0, 0, SEQ, 0, 32'h0, 32'h0, 32'h0, 0, 0};
        tbl[11] = '{0, 1, REL, 1, 32'h0, 32'h20, 32'h0, 0, 0};
        tbl[12] = '{0, 0, STK, 0, 32'h0, 32'h0, 32'h4, 0, 1};
        tbl[13] = '{1, 0, STK, 1, 32'h0, 32'h0, 32'h0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].rst, tbl[i].stl, tbl[i].src, tbl[i].psh,
                  tbl[i].rd, tbl[i].rel);
            chk_state($sformatf("tbl%0d", i), tbl[i].e_pc, tbl[i].e_sp,
                      tbl[i].e_err);
        end

        // Nine calls into an 8-deep stack, then unwind.
        apply(0, 0, REG, 0, 32'h1000, 0);
        for (int i = 0; i < 9; i++) apply(0, 0, SEQ, 1, 0, 0);
        chk_state("ovf", 32'h1024, 8, 1);
        chk("ovf_full", 32'(stack_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, STK, 0, 0, 0);
            chk($sformatf("lifo%0d", i), pc, 32'h1004 + 32'(4 * (7 - i)));
        end
        chk("lifo_empty", 32'(stack_empty), 32'd1);

        // Underflow, then a combined call/return replacing the top.
        apply(1, 0, SEQ, 0, 0, 0);
        apply(0, 0, REG, 0, 32'h20, 0);
        apply(0, 0, STK, 0, 0, 0);
        chk_state("unf", 32'h24, 0, 1);
        apply(0, 0, SEQ, 1, 0, 0);
        apply(0, 0, SEQ, 1, 0, 0);
        chk_state("two", 32'h2C, 2, 1);
        apply(0, 0, STK, 1, 0, 0);
        chk_state("repl", 32'h2C, 2, 1);
        apply(0, 0, STK, 0, 0, 0);
        chk_state("repl_top", 32'h30, 1, 1);
        apply(0, 0, STK, 0, 0, 0);
        chk_state("repl_nxt", 32'h28, 0, 1);

        // Underflow combined with a push still performs the push.
        apply(0, 0, STK, 1, 0, 0);
        chk_state("unf_push", 32'h2C, 1, 1);

        // Stall holds everything; reset overrides stall mid call chain.
        apply(1, 0, SEQ, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, SEQ, 1, 0, 0);
        apply(0, 1, STK, 1, 0, 0);
        apply(0, 1, STK, 1, 0, 0);
        chk_state("stall", 32'hC, 3, 0);
        chk("stall_pcseq", pc_sequency, 32'h10);
        apply(0, 0, SEQ, 1, 0, 0);
        apply(0, 0, SEQ, 1, 0, 0);
        chk_state("sp5", 32'h14, 5, 0);
        apply(1, 1, STK, 1, 0, 0);
        chk_state("rst5", 32'h0, 0, 0);
        chk("rst5_empty", 32'(stack_empty), 32'd1);
        chk("rst5_full", 32'(stack_full), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          s;
            bit          p;
            logic [1:0]  src;
            logic [31:0] rel;
            r   = ($urandom_range(0, 79) == 0);
            s   = ($urandom_range(0, 3) == 0);
            p   = ($urandom_range(0, 99) < ((i % 400) < 200 ? 65 : 25));
            src = 2'($urandom_range(0, 3));
            rel = ($urandom_range(0, 1) != 0) ? $urandom
                                              : 32'($signed(6'($urandom)));
            apply(r, s, src, p, $urandom, rel);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
